// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement.
// Ports: clk, rst_n, start, sgn, A, B in; busy, done, Z (2N-bit product) out.
module seq_shift_add_mult #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, nstate;

  logic [2*N-1:0] maga;
  logic [N-1:0]   magb;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;

  // Magnitude of the most negative value wraps to 2^(N-1),
  // which is exact when read back as unsigned.
  always_comb begin
    abs_a = A;
    abs_b = B;
    if (sgn && A[N-1]) abs_a = ~A + 1'b1;
    if (sgn && B[N-1]) abs_b = ~B + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = CALC;
      CALC:    if (cnt == LAST) nstate = FINAL;
      FINAL:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      CALC:    busy = 1'b1;
      FINAL:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // maga shifts left and magb shifts right, so step i
  // tests magb[i] against magA << i without indexing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maga <= '0;
      magb <= '0;
      acc  <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      Z    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            maga <= {{N{1'b0}}, abs_a};
            magb <= abs_b;
            neg  <= sgn & (A[N-1] ^ B[N-1]);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          if (magb[0]) acc <= acc + maga;
          maga <= maga << 1;
          magb <= magb >> 1;
          cnt  <= cnt + CW'(1);
        end
        FINAL: begin
          Z    <= neg ? (~acc + 1'b1) : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
